trivium_stream_seq: RTL

Host-side sequencer driving the 8-bit byte lane of the Trivium cipher core (`trivium_top`). On `start`, it resets the core and loads the 80-bit key and 80-bit IV one byte per cycle. It then runs the warm-up rounds and streams plaintext bytes from a valid/ready source into the core. Ciphertext bytes are returned on a valid/ready sink through a small output FIFO, so downstream backpressure never corrupts keystream alignment.

---
 rtl/trivium_seq_pkg.sv | 23 ++
 rtl/trivium_seq_fifo.sv | 66 ++++++
 rtl/trivium_stream_seq.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/trivium_seq_pkg.sv
// Shared definitions for the Trivium byte-lane stream sequencer.
// Holds the sequencer state encoding, the default session lengths and the
// width of the per-state cycle counter used by the load and warm-up phases.
package trivium_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CORE_RST,
    ST_LOAD_KEY,
    ST_LOAD_IV,
    ST_WARMUP,
    ST_STREAM,
    ST_DRAIN
  } seq_state_t;

  localparam int DEF_KEY_BYTES     = 10;
  localparam int DEF_IV_BYTES      = 10;
  localparam int DEF_WARMUP_CYCLES = 144;

  // One counter serves key, IV and warm-up phases; warm-up is the longest.
  localparam int WARM_CNT_W = $clog2(DEF_WARMUP_CYCLES);

endpackage

// File: rtl/trivium_seq_fifo.sv
// Synchronous ciphertext FIFO for the Trivium stream sequencer.
// Ports:
//   clk, rst        - clock, synchronous active-high reset (flushes pointers/count)
//   wr_en, wr_data  - write request and byte
//   rd_en           - pop request (ignored when empty)
//   rd_data         - current head entry
//   count           - number of stored entries
//   empty           - no entries stored
// A write while full is accepted when a pop happens in the same cycle.
module trivium_seq_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              full;
  logic              wr_ok;
  logic              rd_ok;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_ok) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only; it needs no reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/trivium_stream_seq.sv
// Host-side sequencer for the 8-bit byte lane of a Trivium core.
// On start it pulses the core reset, loads key then IV (MSB byte first),
// runs the warm-up with zero input, then streams plaintext bytes into the
// core and returns ciphertext through a small FIFO so sink backpressure
// never desynchronises the keystream.
// Optional feature: define TRIVIUM_SEQ_STATS_EN to add a saturating
// delivered-byte counter on output byte_count.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start, stop         - session start (IDLE only) / stream stop (STREAM only)
//   key, iv             - 80-bit key and IV, sampled on accepted start
//   busy                - high whenever not IDLE
//   byte_count          - (stats build only) delivered ciphertext bytes
//   s_data/s_valid/s_ready - plaintext source handshake
//   m_data/m_valid/m_ready - ciphertext sink handshake
//   core_rst_n, core_ena, core_in, core_out - Trivium core byte lane
module trivium_stream_seq
  import trivium_seq_pkg::*;
#(
  parameter int KEY_BYTES     = DEF_KEY_BYTES,
  parameter int IV_BYTES      = DEF_IV_BYTES,
  parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES,
  parameter int CORE_LAT      = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [79:0] key,
  input  logic [79:0] iv,
  output logic        busy,
`ifdef TRIVIUM_SEQ_STATS_EN
  output logic [31:0] byte_count,
`endif
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        core_rst_n,
  output logic        core_ena,
  output logic [7:0]  core_in,
  input  logic [7:0]  core_out
);

  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W      = $clog2(CORE_LAT + 1);
  localparam int OCC_W      = $clog2(FIFO_DEPTH + CORE_LAT + 1);

  seq_state_t             state;
  seq_state_t             state_nxt;
  logic [WARM_CNT_W-1:0]  cnt;
  logic [WARM_CNT_W-1:0]  cnt_nxt;
  logic [79:0]            key_sr;
  logic [79:0]            iv_sr;
  logic                   accept;
  logic [CORE_LAT-1:0]    vld_p;
  logic [INF_W-1:0]       inflight;
  logic [OCC_W-1:0]       occ;
  logic [FIFO_CNT_W-1:0]  fifo_count;
  logic                   fifo_empty;
  logic [7:0]             fifo_head;
  logic                   rd_en;
  logic                   start_ok;

  assign start_ok = (state == ST_IDLE) && start;

  // Accepted bytes still inside the core count against FIFO space so a
  // stalled sink can never overflow the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < CORE_LAT; i++) begin
      inflight = inflight + INF_W'(vld_p[i]);
    end
  end

  assign occ     = OCC_W'(fifo_count) + OCC_W'(inflight);
  assign s_ready = (state == ST_STREAM) && (occ < OCC_W'(FIFO_DEPTH));
  assign accept  = s_valid && s_ready;

  assign busy       = (state != ST_IDLE);
  assign core_rst_n = !rst && (state != ST_CORE_RST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    core_ena  = 1'b0;
    core_in   = 8'h00;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (start) state_nxt = ST_CORE_RST;
      end
      ST_CORE_RST: begin
        cnt_nxt   = '0;
        state_nxt = ST_LOAD_KEY;
      end
      ST_LOAD_KEY: begin
        core_ena = 1'b1;
        core_in  = key_sr[79:72];
        if (cnt == WARM_CNT_W'(KEY_BYTES - 1)) begin
          cnt_nxt   = '0;
          state_nxt = ST_LOAD_IV;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_LOAD_IV: begin
        core_ena = 1'b1;
        core_in  = iv_sr[79:72];
        if (cnt == WARM_CNT_W'(IV_BYTES - 1)) begin
          cnt_nxt   = '0;
          state_nxt = ST_WARMUP;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_WARMUP: begin
        core_ena = 1'b1;
        if (cnt == WARM_CNT_W'(WARMUP_CYCLES - 1)) begin
          cnt_nxt   = '0;
          state_nxt = ST_STREAM;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_STREAM: begin
        // Keystream only advances on accepted plaintext.
        core_ena = accept;
        core_in  = accept ? s_data : 8'h00;
        if (stop) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((inflight == '0) && fifo_empty) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Key/IV bytes are consumed MSB first by shifting left each load cycle.
  always_ff @(posedge clk) begin
    if (start_ok) begin
      key_sr <= key;
      iv_sr  <= iv;
    end else begin
      if (state == ST_LOAD_KEY) key_sr <= {key_sr[71:0], 8'h00};
      if (state == ST_LOAD_IV)  iv_sr  <= {iv_sr[71:0], 8'h00};
    end
  end

  // Stage boundary: core latency tracking, one bit per core cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= accept;
      for (int i = 1; i < CORE_LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  // Stage boundary: ciphertext capture into the output FIFO.
  trivium_seq_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (8),
    .CNT_W  (FIFO_CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (vld_p[CORE_LAT-1]),
    .wr_data (core_out),
    .rd_en   (rd_en),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  assign m_valid = !fifo_empty;
  assign rd_en   = m_valid && m_ready;
  // Head is masked so the unreset storage never shows on the port.
  assign m_data  = m_valid ? fifo_head : 8'h00;

`ifdef TRIVIUM_SEQ_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      byte_count <= '0;
    end else if (rd_en) begin
      byte_count <= sat_inc(byte_count);
    end
  end
`endif

endmodule
